mem_arbiter: RTL and testbench

- Shares one multi-cycle, single-ported main memory between two requesters.
- Requester I is instruction fetch (read-only). Requester D is data access (read/write).
- Sequences each access through a fixed-latency protocol and returns read data with a one-cycle done pulse.
- Sits between the fetch/memory stages and the unified memory, replacing the separate IMEM/DMEM instances.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two requester channels and the memory bus.
//   I channel : i_req, i_addr -> i_done, i_rdata        (fetch, read-only)
//   D channel : d_req, d_wr, d_addr, d_wdata -> d_done, d_rdata
//   memory    : mem_en, mem_wr, mem_addr, mem_wdata -> mem_rdata
// Modports:
//   slave  - the arbiter's view (serves requesters, drives memory)
//   master - the environment's view (requesters plus the memory)
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata,
               mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle single-ported memory between an
// instruction-fetch requester (I, read-only) and a data requester (D, r/w).
// Each access runs IDLE -> BUSY -> DONE; the owner gets a one-cycle done
// pulse with its rdata register updated (reads only).
// Ports:
//   clk  - clock, posedge
//   rst  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave (requester channels + memory bus)
// Parameters: ADDR_W, DATA_W, MEM_LAT (memory read latency, >= 1).
// Build option: define MEM_ARB_RR_EN for round-robin arbitration when both
// requesters are active; otherwise D has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int             CNT_W   = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic             owner_i;  // 1: current access belongs to I
    logic             acc_wr;   // current access is a write
    logic [CNT_W-1:0] cnt;      // remaining BUSY cycles after this one
    logic             grant_i;  // in IDLE: I wins if any request is up

`ifdef MEM_ARB_RR_EN
    logic rr_i;                 // pointer: 1 = I preferred on a tie
    always_comb grant_i = bus.i_req && (!bus.d_req || rr_i);
`else
    always_comb grant_i = bus.i_req && !bus.d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner_i       <= 1'b0;
            acc_wr        <= 1'b0;
            cnt           <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_done    <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
            rr_i          <= 1'b0;
`endif
        end else begin
            // done pulses last exactly the single DONE cycle
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        owner_i       <= grant_i;
                        acc_wr        <= !grant_i && bus.d_wr;
                        bus.mem_en    <= 1'b1;
                        bus.mem_wr    <= !grant_i && bus.d_wr;
                        bus.mem_addr  <= grant_i ? bus.i_addr : bus.d_addr;
                        bus.mem_wdata <= grant_i ? '0 : bus.d_wdata;
                        // writes finish in one BUSY cycle; reads wait MEM_LAT
                        cnt           <= (grant_i || !bus.d_wr) ? RD_LOAD : '0;
`ifdef MEM_ARB_RR_EN
                        rr_i          <= !grant_i;
`endif
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    bus.mem_wr <= 1'b0;  // write strobe only in first BUSY cycle
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        if (!acc_wr) begin
                            if (owner_i) bus.i_rdata <= bus.mem_rdata;
                            else         bus.d_rdata <= bus.mem_rdata;
                        end
                        bus.mem_en <= 1'b0;
                        bus.i_done <= owner_i;
                        bus.d_done <= !owner_i;
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;  // requests ignored here
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Two DUTs: MEM_LAT=4 (main) and MEM_LAT=1. Each has a behavioural memory.
// Expected results come from a transaction-level model: a reference memory
// image, the expected rdata of each requester, the arbitration rule and the
// documented per-access latencies.
module tb_mem_arbiter;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus  ();
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .bus(bus));
    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    // behavioural memories, with a backdoor preload port
    logic [15:0] mem0 [0:65535];
    logic [15:0] mem1 [0:65535];
    logic        pre_we   = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem0[pre_addr] <= pre_data;
            mem1[pre_addr] <= pre_data;
        end else begin
            if (bus.mem_en && bus.mem_wr)   mem0[bus.mem_addr]  <= bus.mem_wdata;
            if (bus1.mem_en && bus1.mem_wr) mem1[bus1.mem_addr] <= bus1.mem_wdata;
        end
    end
    assign bus.mem_rdata  = mem0[bus.mem_addr];
    assign bus1.mem_rdata = mem1[bus1.mem_addr];

    // reference model state
    logic [15:0] ref_mem [0:65535];
    logic [15:0] exp_ir = '0;
    logic [15:0] exp_dr = '0;
    bit          ptr_i  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit pick_i(input bit ri, input bit rd);
`ifdef MEM_ARB_RR_EN
        return ri && (!rd || ptr_i);
`else
        return ri && !rd;
`endif
    endfunction

    function automatic int lat(input bit wr);
        return wr ? 2 : LAT + 1;
    endfunction

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
    endtask

    task automatic apply(input bit ri, input logic [15:0] ia, input bit rd, input bit dw,
                         input logic [15:0] da, input logic [15:0] dwd);
        bus.i_req = ri; bus.i_addr = ia;
        bus.d_req = rd; bus.d_wr = dw; bus.d_addr = da; bus.d_wdata = dwd;
    endtask

    // counts cycles from an IDLE-cycle negedge until a done is seen
    task automatic wait_done(output bit gi, output bit gd, output int cyc);
        gi = 0; gd = 0; cyc = 0;
        while (!gi && !gd && cyc < 40) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            gi = bus.i_done; gd = bus.d_done;
        end
        if (!gi && !gd) check("done_timeout", {gi, gd}, 2'b01);
        else            check("done_exclusive", gi && gd, 1'b0);
    endtask

    task automatic finish_access(input string tag, input bit exp_i, input bit is_wr,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input int exp_cyc);
        bit gi, gd;
        int cyc;
        wait_done(gi, gd, cyc);
        check({tag, "_owner"}, {gi, gd}, exp_i ? 2'b10 : 2'b01);
        check({tag, "_lat"}, cyc, exp_cyc);
        if (is_wr)      ref_mem[addr] = wdata;
        else if (exp_i) exp_ir = ref_mem[addr];
        else            exp_dr = ref_mem[addr];
        ptr_i = !exp_i;
        check({tag, "_i_rdata"}, bus.i_rdata, exp_ir);
        check({tag, "_d_rdata"}, bus.d_rdata, exp_dr);
    endtask

    // single access on the MEM_LAT=1 instance, checked cycle by cycle
    task automatic dut1_access(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                               input logic [15:0] exp_rd);
        bus1.d_req = 1'b1; bus1.d_wr = wr; bus1.d_addr = a; bus1.d_wdata = wd;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); @(negedge clk);
            check("lat1_mem_en", bus1.mem_en, c == 1);
            check("lat1_d_done", bus1.d_done, c == 2);
            if (c == 2) begin
                check("lat1_d_rdata", bus1.d_rdata, exp_rd);
                bus1.d_req = 1'b0;
            end
        end
    endtask

    typedef struct {
        bit          ri;
        logic [15:0] ia;
        bit          rd;
        bit          dw;
        logic [15:0] da;
        logic [15:0] dwd;
        bit          exp_i;
        int          exp_cyc;
        logic [15:0] exp_rdata;  // owner's rdata after done
    } vec_t;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs [9];
        bit gi, gd, first, ri, rd, dw;
        int cyc;
        logic [15:0] ia, da, dwd;

        apply(0, '0, 0, 0, '0, '0);
        bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_wr = 0;
        bus1.d_addr = '0; bus1.d_wdata = '0;

        vecs[0] = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, LAT + 1, 16'hA5C3};
        vecs[1] = '{0, 16'h0000, 1, 1, 16'h0300, 16'hC0DE, 0, 2,       16'h1234};
        vecs[2] = '{0, 16'h0000, 1, 0, 16'h0300, 16'h0000, 0, LAT + 1, 16'hC0DE};
        vecs[3] = '{0, 16'h0000, 1, 1, 16'hFFFF, 16'hBEEF, 0, 2,       16'hC0DE};
        vecs[4] = '{1, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 1, LAT + 1, 16'hBEEF};
        vecs[5] = '{0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, LAT + 1, 16'h0F0F};
        vecs[6] = '{1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 1, LAT + 1, 16'h1234};
        vecs[7] = '{0, 16'h0000, 1, 1, 16'h0010, 16'h55AA, 0, 2,       16'h0F0F};
        vecs[8] = '{0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, LAT + 1, 16'h55AA};

        // preload while in reset
        preload(16'h0010, 16'hA5C3);
        preload(16'h0000, 16'h0F0F);
        preload(16'h0100, 16'h0000);
        preload(16'h0002, 16'h5A5A);
        for (int i = 0; i < 16; i++) preload(16'h0040 + 16'(i), 16'h1000 + 16'(i * 16'h0111));
        @(negedge clk);
        pre_we = 1'b0;

        // reset state
        check("rst_mem_en",    bus.mem_en,    1'b0);
        check("rst_mem_wr",    bus.mem_wr,    1'b0);
        check("rst_mem_addr",  bus.mem_addr,  16'h0);
        check("rst_mem_wdata", bus.mem_wdata, 16'h0);
        check("rst_i_done",    bus.i_done,    1'b0);
        check("rst_d_done",    bus.d_done,    1'b0);
        check("rst_i_rdata",   bus.i_rdata,   16'h0);
        check("rst_d_rdata",   bus.d_rdata,   16'h0);
        check("rst1_mem_en",   bus1.mem_en,   1'b0);
        rst = 1'b0;
        @(negedge clk);

        // I read of 0x0010, cycle by cycle
        apply(1, 16'h0010, 0, 0, '0, '0);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); @(negedge clk);
            check("iread_mem_en", bus.mem_en, c <= 4);
            check("iread_mem_wr", bus.mem_wr, 1'b0);
            if (c <= 4) check("iread_mem_addr", bus.mem_addr, 16'h0010);
            check("iread_i_done", bus.i_done, c == 5);
            check("iread_d_done", bus.d_done, 1'b0);
            if (c == 5) begin
                check("iread_i_rdata", bus.i_rdata, 16'hA5C3);
                bus.i_req = 1'b0;
            end
        end
        exp_ir = 16'hA5C3; ptr_i = 1'b0;

        // D write 0x0100 <- 0x1234, cycle by cycle, then read back
        apply(0, '0, 1, 1, 16'h0100, 16'h1234);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); @(negedge clk);
            check("dwr_mem_wr", bus.mem_wr, c == 1);
            check("dwr_mem_en", bus.mem_en, c == 1);
            if (c == 1) begin
                check("dwr_mem_addr",  bus.mem_addr,  16'h0100);
                check("dwr_mem_wdata", bus.mem_wdata, 16'h1234);
            end
            check("dwr_d_done", bus.d_done, c == 2);
            if (c == 2) begin
                check("dwr_d_rdata_kept", bus.d_rdata, exp_dr);
                bus.d_req = 1'b0;
            end
        end
        ref_mem[16'h0100] = 16'h1234; ptr_i = 1'b1;
        apply(0, '0, 1, 0, 16'h0100, '0);
        finish_access("drd_back", 0, 0, 16'h0100, '0, LAT + 1);
        bus.d_req = 1'b0;
        @(negedge clk);

        // table of single-requester accesses
        for (int v = 0; v < 9; v++) begin
            apply(vecs[v].ri, vecs[v].ia, vecs[v].rd, vecs[v].dw, vecs[v].da, vecs[v].dwd);
            finish_access($sformatf("vec%0d", v), vecs[v].exp_i,
                          vecs[v].rd && vecs[v].dw,
                          vecs[v].ri ? vecs[v].ia : vecs[v].da, vecs[v].dwd, vecs[v].exp_cyc);
            check($sformatf("vec%0d_table_rdata", v),
                  vecs[v].exp_i ? bus.i_rdata : bus.d_rdata, vecs[v].exp_rdata);
            apply(0, '0, 0, 0, '0, '0);
            @(negedge clk);
        end

        // both requests in the same IDLE cycle
        apply(1, 16'h0040, 1, 0, 16'h0041, '0);
        first = pick_i(1, 1);
        finish_access("both_first", first, 0, first ? 16'h0040 : 16'h0041, '0, LAT + 1);
        if (first) bus.i_req = 1'b0; else bus.d_req = 1'b0;
        finish_access("both_second", !first, 0, first ? 16'h0041 : 16'h0040, '0, LAT + 2);
        apply(0, '0, 0, 0, '0, '0);
        @(negedge clk);

        // both held continuously for four accesses
        apply(1, 16'h0042, 1, 0, 16'h0043, '0);
        for (int k = 0; k < 4; k++) begin
            first = pick_i(1, 1);
            finish_access($sformatf("hold%0d", k), first, 0,
                          first ? 16'h0042 : 16'h0043, '0, (k == 0) ? LAT + 1 : LAT + 2);
        end
        apply(0, '0, 0, 0, '0, '0);
        @(negedge clk);

        // randomized traffic against the model
        for (int r = 0; r < 40; r++) begin
            ri  = bit'($urandom_range(0, 1));
            rd  = ri ? bit'($urandom_range(0, 1)) : 1'b1;
            dw  = bit'($urandom_range(0, 1));
            ia  = 16'h0040 + 16'($urandom_range(0, 15));
            da  = 16'h0040 + 16'($urandom_range(0, 15));
            dwd = 16'($urandom);
            apply(ri, ia, rd, dw, da, dwd);
            first = pick_i(ri, rd);
            finish_access("rnd_a", first, !first && dw, first ? ia : da, dwd,
                          lat(!first && dw));
            if (first) bus.i_req = 1'b0; else bus.d_req = 1'b0;
            if (ri && rd) begin
                finish_access("rnd_b", !first, first && dw, first ? da : ia, dwd,
                              lat(first && dw) + 1);
            end
            apply(0, '0, 0, 0, '0, '0);
            @(negedge clk);
        end

        // reset in the middle of a read
        apply(1, 16'h0010, 0, 0, '0, '0);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        bus.i_req = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rstmid_mem_en",  bus.mem_en,  1'b0);
        check("rstmid_i_rdata", bus.i_rdata, 16'h0);
        check("rstmid_d_rdata", bus.d_rdata, 16'h0);
        exp_ir = '0; exp_dr = '0; ptr_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) rst = 1'b0;
            @(posedge clk); @(negedge clk);
            check("rstmid_no_done", {bus.i_done, bus.d_done}, 2'b00);
        end
        apply(0, '0, 1, 0, 16'h0000, '0);
        @(posedge clk); @(negedge clk);
        check("rstmid_regrant_en",   bus.mem_en,   1'b1);
        check("rstmid_regrant_addr", bus.mem_addr, 16'h0000);
        finish_access("rstmid_rd", 0, 0, 16'h0000, '0, LAT);
        apply(0, '0, 0, 0, '0, '0);
        @(negedge clk);

        // MEM_LAT = 1 instance
        dut1_access(0, 16'h0002, '0, 16'h5A5A);
        dut1_access(1, 16'h0003, 16'h7777, 16'h5A5A);
        dut1_access(0, 16'h0003, '0, 16'h7777);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
